vc_input_buffer6: RTL and testbench
===================================

# vc_input_buffer6

Six-VC input buffer bank that supplies per-VC head-flit timestamps to the 6-to-1 oldest-first VC arbiter and dequeues the VC the arbiter selects. Incoming flits are written into one of six per-VC FIFOs; each FIFO's head timestamp drives one arbiter `time_in_N` input; the arbiter's winner index returns here as the read select. The block sits between the link receiver and the VC arbiter inside each router input port.

## Interface
- `TIME_WIDTH`, 8: timestamp width; equals the global `TIME_WIDTH`.
- `VC_INDEX_WIDTH`, 3: VC index width; equals the global `VC_INDEX_WIDTH`.
- `DATA_WIDTH`, 64: flit payload width.
- `DEPTH`, 4: entries per VC FIFO; a power of two, ≥2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write request.
- `wr_vc` in VC_INDEX_WIDTH: target VC.
- `wr_time` in TIME_WIDTH: flit timestamp.
- `wr_data` in DATA_WIDTH: flit payload.
- `rd_en` in 1: pop request.
- `rd_vc` in VC_INDEX_WIDTH: VC to pop; driven by the arbiter winner index.
- `time_out_0` … `time_out_5` out TIME_WIDTH: head timestamp per VC; drive arbiter `time_in_0..5`.
- `rd_data` out DATA_WIDTH: head payload of `rd_vc`.
- `rd_time` out TIME_WIDTH: head timestamp of `rd_vc`.
- `empty_out` out 6: per-VC empty flags.
- `full_out` out 6: per-VC full flags.
- `err_out` out 1: sticky protocol-error flag.
- `credit_out` out 6: per-VC credit pulse; present only with `VC_BUF_CREDIT_EN`.

## Operation
- Each VC is a circular FIFO with its own read pointer, write pointer, and occupancy counter. The counter is `log2(DEPTH)+1` bits wide. Pointers are `log2(DEPTH)` bits and wrap from DEPTH-1 to 0.
- Head presentation is combinational from storage and the read pointer:
  - Non-empty VC: `time_out_N` = stored head timestamp.
  - Empty VC: `time_out_N` = all-ones. An empty VC therefore never beats an occupied VC whose timestamp is below all-ones.
- `rd_data` and `rd_time` are combinational muxes on `rd_vc` (first-word fall-through). If `rd_vc` is 6 or 7, or the selected VC is empty, both outputs are 0.
- Write: when `wr_en` is high, `wr_vc` is 0–5, and the VC is not full, the block stores {wr_time, wr_data} at the write pointer and increments the pointer and count.
- Pop: when `rd_en` is high, `rd_vc` is 0–5, and the VC is non-empty, the block increments the read pointer and decrements the count.
- Simultaneous write and pop:
  - Different VCs: both are performed independently.
  - Same VC: both are performed and the count is unchanged. A write to a full VC is accepted if the same VC is popped in that cycle. A write to an empty VC in the same cycle as a pop of that VC is a pop-on-empty; the write proceeds and the pop is ignored.
- Error cases set `err_out`, which stays high until reset. The offending operation is dropped and has no other effect:
  - write to a full VC without a same-cycle pop of that VC;
  - pop of an empty VC;
  - `wr_vc` or `rd_vc` of 6 or 7 while the matching enable is high.
- Storage arrays are not reset; only pointers, counters, flags, and `err_out` are reset.

## Timing
- Reset (asynchronous assert):
  - all pointers and counts = 0;
  - `empty_out` = 6'b111111, `full_out` = 0;
  - `time_out_N` = all-ones;
  - `rd_data` = 0, `rd_time` = 0;
  - `err_out` = 0, `credit_out` = 0.
- Reset asserted mid-operation discards all buffered flits immediately.
- Write-to-visible latency is 1 cycle. A flit written at edge k appears on `time_out_N` and clears `empty_out[N]` right after edge k.
- Pop takes effect at the edge. The next entry, or all-ones if the VC is now empty, is presented right after that edge.
- `empty_out` and `full_out` are registered, derived from the next-state count.
- Read path for a given cycle: arbiter output → `rd_vc` → `rd_data`. The loop is combinational within the cycle, and there is no combinational path from `rd_en`/`rd_vc` to `time_out_N`.

## Configuration
- `VC_BUF_CREDIT_EN` defined: the block adds the `credit_out` port and registers a one-cycle pulse on `credit_out[N]` in the cycle after each successful pop of VC N. Simultaneous pops cannot occur, so at most one credit bit is high per cycle.
- `VC_BUF_CREDIT_EN` undefined: the `credit_out` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle:
  - `empty_out`=6'h3F, `full_out`=0, `err_out`=0;
  - all `time_out_N`=8'hFF.
- Write VC2 t=8'h10, then VC4 t=8'h05; feed outputs to the arbiter:
  - `time_out_2`=10, `time_out_4`=05;
  - arbiter selects 4; pop VC4 → `time_out_4`=FF, `empty_out[4]`=1, next winner 2.
- Fill VC0 with DEPTH=4 flits t=1,2,3,4:
  - `full_out[0]`=1;
  - 5th write → dropped, `err_out`=1;
  - pops return t=1,2,3,4 in order; pointer wraps correctly on a second fill.
- VC1 full; same cycle write VC1 t=9 and pop VC1:
  - count stays 4, no error;
  - after four pops the last `rd_time`=9.
- Pop empty VC3, and separately `wr_vc`=6:
  - each operation is dropped and sets `err_out`;
  - with `VC_BUF_CREDIT_EN`, a pop of VC5 gives a single `credit_out`=6'b100000 pulse one cycle after the pop.
- Assert `rst_n` low mid-stream with VC0 half full:
  - outputs return to reset values asynchronously;
  - after release, the first write to VC0 is the head.

Source files
------------

// File: rtl/vc_input_buffer6.sv
// Six-VC input buffer bank: per-VC circular FIFOs that present head timestamps to the
// oldest-first VC arbiter and pop the winner. Optional feature macro: VC_BUF_CREDIT_EN.
module vc_input_buffer6 #(
    parameter int TIME_WIDTH     = 8,
    parameter int VC_INDEX_WIDTH = 3,
    parameter int DATA_WIDTH     = 64,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [VC_INDEX_WIDTH-1:0] wr_vc,
    input  logic [TIME_WIDTH-1:0]     wr_time,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    input  logic [VC_INDEX_WIDTH-1:0] rd_vc,
    output logic [TIME_WIDTH-1:0]     time_out_0,
    output logic [TIME_WIDTH-1:0]     time_out_1,
    output logic [TIME_WIDTH-1:0]     time_out_2,
    output logic [TIME_WIDTH-1:0]     time_out_3,
    output logic [TIME_WIDTH-1:0]     time_out_4,
    output logic [TIME_WIDTH-1:0]     time_out_5,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [TIME_WIDTH-1:0]     rd_time,
    output logic [5:0]                empty_out,
    output logic [5:0]                full_out,
`ifdef VC_BUF_CREDIT_EN
    output logic [5:0]                credit_out,
`endif
    output logic                      err_out
);

    localparam int NUM_VC = 6;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TIME_WIDTH-1:0] mem_time [NUM_VC][DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [NUM_VC][DEPTH];

    logic [PTR_W-1:0]      rd_ptr   [NUM_VC];
    logic [PTR_W-1:0]      wr_ptr   [NUM_VC];
    logic [CNT_W-1:0]      cnt      [NUM_VC];
    logic [CNT_W-1:0]      cnt_nxt  [NUM_VC];
    logic [TIME_WIDTH-1:0] head_time[NUM_VC];

    logic [NUM_VC-1:0] wr_sel, rd_sel, push_v, pop_v;
    logic [NUM_VC-1:0] empty_q, full_q;
    logic              err_q, wr_err, rd_err;

    // A write to a full VC is legal only when that same VC is popped this cycle;
    // a pop of an empty VC is always dropped, even if the same VC is written.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wr_sel = '0;
        rd_sel = '0;
        push_v = '0;
        pop_v  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel[v]  = wr_en && (wr_vc == VC_INDEX_WIDTH'(v));
            rd_sel[v]  = rd_en && (rd_vc == VC_INDEX_WIDTH'(v));
            pop_v[v]   = rd_sel[v] && (cnt[v] != '0);
            push_v[v]  = wr_sel[v] && ((cnt[v] != FULL_CNT) || pop_v[v]);
            cnt_nxt[v] = cnt[v] + CNT_W'(push_v[v]) - CNT_W'(pop_v[v]);
        end
        wr_err = wr_en && !(|push_v);
        rd_err = rd_en && !(|pop_v);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                cnt[v]    <= '0;
            end
            empty_q <= '1;
            full_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_v[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop_v[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                cnt[v]     <= cnt_nxt[v];
                empty_q[v] <= (cnt_nxt[v] == '0);
                full_q[v]  <= (cnt_nxt[v] == FULL_CNT);
            end
            err_q <= err_q || wr_err || rd_err;
        end
    end

    // NOTE: flit storage has no reset; empty flags mask stale entries, so clearing
    // the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_v[v]) begin
                mem_time[v][wr_ptr[v]] <= wr_time;
                mem_data[v][wr_ptr[v]] <= wr_data;
            end
        end
    end

    // Head timestamps depend only on registered state, never on rd_en/rd_vc.
    always_comb begin
        rd_data = '0;
        rd_time = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            head_time[v] = empty_q[v] ? '1 : mem_time[v][rd_ptr[v]];
            if (rd_vc == VC_INDEX_WIDTH'(v) && !empty_q[v]) begin
                rd_data = mem_data[v][rd_ptr[v]];
                rd_time = mem_time[v][rd_ptr[v]];
            end
        end
    end

    assign time_out_0 = head_time[0];
    assign time_out_1 = head_time[1];
    assign time_out_2 = head_time[2];
    assign time_out_3 = head_time[3];
    assign time_out_4 = head_time[4];
    assign time_out_5 = head_time[5];
    assign empty_out  = empty_q;
    assign full_out   = full_q;
    assign err_out    = err_q;

`ifdef VC_BUF_CREDIT_EN
    logic [NUM_VC-1:0] credit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) credit_q <= '0;
        else        credit_q <= pop_v;
    end

    assign credit_out = credit_q;
`endif

endmodule

// File: tb/tb_vc_input_buffer6.sv
// Randomized self-checking bench for vc_input_buffer6 against a queue-based model;
// define VC_BUF_CREDIT_EN to also check credit_out.
module tb_vc_input_buffer6;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0]  t;
        logic [63:0] d;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en;
    logic [2:0]  wr_vc, rd_vc;
    logic [7:0]  wr_time;
    logic [63:0] wr_data;
    logic [7:0]  time_out_0, time_out_1, time_out_2, time_out_3, time_out_4, time_out_5;
    logic [63:0] rd_data;
    logic [7:0]  rd_time;
    logic [5:0]  empty_out, full_out;
    logic        err_out;
`ifdef VC_BUF_CREDIT_EN
    logic [5:0]  credit_out;
`endif

    logic [7:0]  tout [6];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue of flits per VC, sticky error, expected credit.
    flit_t      q [6][$];
    logic       m_err;
    logic [5:0] m_credit;

    always #5 clk = ~clk;

    vc_input_buffer6 #(.TIME_WIDTH(8), .VC_INDEX_WIDTH(3), .DATA_WIDTH(64), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_vc      (wr_vc),
        .wr_time    (wr_time),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_vc      (rd_vc),
        .time_out_0 (time_out_0),
        .time_out_1 (time_out_1),
        .time_out_2 (time_out_2),
        .time_out_3 (time_out_3),
        .time_out_4 (time_out_4),
        .time_out_5 (time_out_5),
        .rd_data    (rd_data),
        .rd_time    (rd_time),
        .empty_out  (empty_out),
        .full_out   (full_out),
`ifdef VC_BUF_CREDIT_EN
        .credit_out (credit_out),
`endif
        .err_out    (err_out)
    );

    assign tout[0] = time_out_0;
    assign tout[1] = time_out_1;
    assign tout[2] = time_out_2;
    assign tout[3] = time_out_3;
    assign tout[4] = time_out_4;
    assign tout[5] = time_out_5;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [5:0] e_empty, e_full;
        flit_t      h;
        for (int v = 0; v < 6; v++) begin
            e_empty[v] = (q[v].size() == 0);
            e_full[v]  = (q[v].size() == DEPTH);
            check($sformatf("time_out_%0d", v), 64'(tout[v]),
                  e_empty[v] ? 64'hFF : 64'(q[v][0].t));
        end
        check("empty_out", 64'(empty_out), 64'(e_empty));
        check("full_out", 64'(full_out), 64'(e_full));
        check("err_out", 64'(err_out), 64'(m_err));
        if (rd_vc < 3'd6 && q[rd_vc].size() != 0) h = q[rd_vc][0];
        else h = '0;
        check("rd_time", 64'(rd_time), 64'(h.t));
        check("rd_data", rd_data, h.d);
`ifdef VC_BUF_CREDIT_EN
        check("credit_out", 64'(credit_out), 64'(m_credit));
`endif
    endtask

    // Applies the edge's effect from the buffer rules, using the inputs held this cycle.
    task automatic model_step();
        logic  pop_ok, push_ok;
        flit_t f;
        pop_ok  = rd_en && rd_vc < 3'd6 && q[rd_vc].size() != 0;
        push_ok = wr_en && wr_vc < 3'd6 &&
                  (q[wr_vc].size() < DEPTH || (pop_ok && rd_vc == wr_vc));
        if (wr_en && !push_ok) m_err = 1'b1;
        if (rd_en && !pop_ok)  m_err = 1'b1;
        m_credit = '0;
        if (pop_ok) begin
            void'(q[rd_vc].pop_front());
            m_credit[rd_vc] = 1'b1;
        end
        if (push_ok) begin
            f.t = wr_time;
            f.d = wr_data;
            q[wr_vc].push_back(f);
        end
    endtask

    // Called at a falling edge: drive, check pre-edge outputs, clock, update model.
    task automatic cycle(input logic we, input logic [2:0] wv, input logic [7:0] wt,
                         input logic re, input logic [2:0] rv);
        wr_en   = we;
        wr_vc   = wv;
        wr_time = wt;
        wr_data = {$urandom, $urandom};
        rd_en   = re;
        rd_vc   = rv;
        #1 check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int v = 0; v < 6; v++) q[v].delete();
        m_err    = 1'b0;
        m_credit = '0;
    endtask

    // Reset asserted away from the rising edge: outputs must drop before any clock.
    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst_n = 1'b0;
        clear_model();
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_vc = '0; wr_time = '0; wr_data = '0;
        rd_en = 1'b0; rd_vc = '0;
        clear_model();
        repeat (2) @(negedge clk);
        do_reset();
        cycle(0, 0, 0, 0, 0);

        // Two VCs with different ages; oldest (VC4) wins and is popped first.
        cycle(1, 2, 8'h10, 0, 0);
        cycle(1, 4, 8'h05, 0, 4);
        check("time_out_4 after writes", 64'(time_out_4), 64'h05);
        cycle(0, 0, 0, 1, 4);
        check("time_out_4 after pop", 64'(time_out_4), 64'hFF);
        cycle(0, 0, 0, 1, 2);

        // Fill VC0, overflow, drain, then a second fill to exercise pointer wrap.
        for (int k = 1; k <= 4; k++) cycle(1, 0, 8'(k), 0, 0);
        cycle(1, 0, 8'h05, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(1, 0, 8'(8'h20 + k), 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);

        // Full VC1 with a same-cycle write and pop stays full and raises no error.
        do_reset();
        for (int k = 1; k <= 4; k++) cycle(1, 1, 8'(k), 0, 1);
        cycle(1, 1, 8'h09, 1, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 1);
        check("last rd_time of VC1", 64'(rd_time), 64'h09);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);

        // Protocol errors, each from a clean reset.
        do_reset();
        cycle(0, 0, 0, 1, 3);
        cycle(0, 0, 0, 0, 0);
        do_reset();
        cycle(1, 6, 8'h33, 0, 0);
        cycle(0, 0, 0, 0, 0);
        do_reset();
        cycle(1, 5, 8'h44, 0, 5);
        cycle(0, 0, 0, 1, 5);
        cycle(0, 0, 0, 0, 5);
        cycle(0, 0, 0, 0, 5);

        // Reset with VC0 half full; the first post-reset write becomes the head.
        cycle(1, 0, 8'h61, 0, 0);
        cycle(1, 0, 8'h62, 0, 0);
        do_reset();
        cycle(1, 0, 8'h70, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic       we, re;
            logic [2:0] wv, rv;
            if ($urandom_range(0, 299) == 0) do_reset();
            we = ($urandom_range(0, 9) < 6);
            re = ($urandom_range(0, 9) < 5);
            wv = ($urandom_range(0, 39) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            rv = ($urandom_range(0, 39) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            cycle(we, wv, 8'($urandom), re, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
